apb_timeout_guard: RTL and testbench
====================================

# apb_timeout_guard

- Sits between the AXI-to-APB bridge and the peripheral bus wrapper.
- Forwards every APB transfer to the peripheral decoder unchanged.
- If the selected peripheral holds PREADY low past a programmable bound, it aborts the transfer towards the core and returns an error. The core therefore never hangs on a dead or unmapped peripheral.
- Records the address of the last aborted transfer for software diagnosis.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, address width of both sides
- APB_DATA_WIDTH, 32, data width of both sides
- TIMEOUT_CYCLES, 1024, maximum access-phase cycles allowed before abort; legal range 2..65535

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  asynchronous active-low reset
- Upstream request (from the bridge):
  - slv_psel_i / slv_penable_i / slv_pwrite_i  in  1 each  upstream APB control
  - slv_paddr_i  in  APB_ADDR_WIDTH  upstream address
  - slv_pwdata_i  in  APB_DATA_WIDTH  upstream write data
- Upstream response (to the bridge):
  - slv_prdata_o  out  APB_DATA_WIDTH  read data to upstream
  - slv_pready_o / slv_pslverr_o  out  1 each  response to upstream
- Downstream request (to the bus wrapper):
  - mst_psel_o / mst_penable_o / mst_pwrite_o  out  1 each  downstream control
  - mst_paddr_o  out  APB_ADDR_WIDTH  downstream address
  - mst_pwdata_o  out  APB_DATA_WIDTH  downstream write data
- Downstream response (from the bus wrapper):
  - mst_prdata_i  in  APB_DATA_WIDTH  downstream read data
  - mst_pready_i / mst_pslverr_i  in  1 each  downstream response
- Status:
  - err_o  out  1  one-cycle pulse per aborted transfer
  - err_addr_o  out  APB_ADDR_WIDTH  address of last aborted transfer
  - err_cnt_o  out  8  saturating abort count

## Operation
States:
- IDLE: no transfer in progress.
- SETUP: the APB setup cycle of a transfer.
- ACCESS: the access phase, with the wait counter running.
- ABORT: the one-cycle error response after a timeout.

Transitions:
- IDLE -> SETUP on slv_psel_i=1, slv_penable_i=0.
- SETUP -> ACCESS on the next cycle. The counter clears to 0 on entering ACCESS.
- In ACCESS:
  - mst_pready_i=1 -> IDLE, or SETUP if a new setup is presented.
  - Otherwise the counter increments each cycle.
  - When the counter equals TIMEOUT_CYCLES-1 and mst_pready_i=0 -> ABORT.
- ABORT -> IDLE unconditionally.
- In any state, slv_psel_i=0 (upstream protocol violation or end of transfer) -> IDLE. The counter clears and no error is raised.

Path in IDLE, SETUP and ACCESS:
- Downstream outputs equal the upstream inputs combinationally.
- Upstream response outputs equal the downstream response inputs.

Path in ABORT:
- mst_psel_o=0 and mst_penable_o=0; other downstream outputs still pass through.
- slv_pready_o=1, slv_pslverr_o=1, slv_prdata_o = 0xDEADBEEF truncated or zero-extended to APB_DATA_WIDTH.
- err_o=1 for this cycle.
- err_addr_o <= slv_paddr_i.
- err_cnt_o increments and saturates at 255.

Counter:
- Width is clog2(TIMEOUT_CYCLES).
- It never wraps, because ABORT is taken at the terminal count.

## Timing
- Reset values:
  - state = IDLE and counter = 0.
  - err_o=0, err_addr_o=0, err_cnt_o=0.
  - Pass-through outputs follow their inputs.
- Zero added latency on successful transfers: a response on mst_pready_i is visible on slv_pready_o in the same cycle.
- Abort timing: the first access cycle is cycle 0. If mst_pready_i is 0 on cycles 0..TIMEOUT_CYCLES-1, then slv_pready_o=1 with slv_pslverr_o=1 on cycle TIMEOUT_CYCLES.
- Boundary conditions:
  - mst_pready_i=1 on cycle TIMEOUT_CYCLES-1 completes normally; no abort.
  - A late mst_pready_i arriving in the ABORT cycle is ignored.
  - Back-to-back transfers: a new SETUP in the cycle after completion or abort is accepted, and the counter restarts.
  - An abort while err_cnt_o=255 keeps it at 255; err_addr_o still updates.
  - Reset asserted mid-ACCESS returns to IDLE immediately (asynchronous) with all registers at reset values.

## Configuration
- Macro: APB_TIMEOUT_ERR_LOG_EN.
- Defined: the err_addr_o and err_cnt_o registers are implemented as described.
- Undefined: err_addr_o and err_cnt_o are tied to 0 and their registers are removed. err_o and the abort behaviour are unchanged.

## Test plan
Bench uses TIMEOUT_CYCLES=16 with APB_TIMEOUT_ERR_LOG_EN defined.

- Write 0x1234 to 0x1A10_0000; slave asserts PREADY on access cycle 2 -> completion on that cycle, slv_pslverr_o=0, err_o never pulses, err_cnt_o=0.
- Read from 0x1A10_1000; slave never asserts PREADY -> on access cycle 16:
  - slv_pready_o=1, slv_pslverr_o=1, slv_prdata_o=0xDEADBEEF, mst_psel_o=0;
  - err_o pulses once, err_addr_o=0x1A10_1000, err_cnt_o=1.
- Slave asserts PREADY exactly on access cycle 15 -> normal completion, no error, err_cnt_o unchanged.
- 300 consecutive timed-out transfers -> err_cnt_o=255 and held; err_addr_o equals the last address.
- Reset asserted on access cycle 8 of a stalled transfer -> state IDLE; err_o/err_addr_o/err_cnt_o=0; after reset release, the next transfer completes normally.
- Upstream drops slv_psel_i on access cycle 5 -> state IDLE, counter 0, no error pulse; a following SETUP starts a fresh 16-cycle window.

Source files
------------

// File: rtl/apb_timeout_guard.sv
// APB pass-through that aborts an access phase stalled longer than TIMEOUT_CYCLES with PSLVERR.
// Optional macro APB_TIMEOUT_ERR_LOG_EN keeps the last abort address and a saturating abort count.
module apb_timeout_guard #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      slv_psel_i,
  input  logic                      slv_penable_i,
  input  logic                      slv_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] slv_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] slv_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] slv_prdata_o,
  output logic                      slv_pready_o,
  output logic                      slv_pslverr_o,
  output logic                      mst_psel_o,
  output logic                      mst_penable_o,
  output logic                      mst_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] mst_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] mst_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] mst_prdata_i,
  input  logic                      mst_pready_i,
  input  logic                      mst_pslverr_i,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] err_addr_o,
  output logic [7:0]                err_cnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [APB_DATA_WIDTH+31:0] ERR_EXT = {{APB_DATA_WIDTH{1'b0}}, 32'hDEADBEEF};
  localparam logic [APB_DATA_WIDTH-1:0] ERR_DATA = ERR_EXT[APB_DATA_WIDTH-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ABORT} state_e;

  state_e           r_state;
  state_e           w_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The setup cycle is recognised in the cycle it is presented, so the
  // registered state is ACCESS with a zero count on the first access cycle.
  always_comb begin
    w_state     = ST_IDLE;
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = '0;

    if (r_state == ST_ABORT) begin
      w_state = ST_ABORT;
    end else if (!slv_psel_i) begin
      w_state = ST_IDLE;
    end else if (!slv_penable_i) begin
      w_state = ST_SETUP;
    end else if (r_state == ST_ACCESS) begin
      w_state = ST_ACCESS;
    end else begin
      w_state = ST_IDLE;
    end

    case (w_state)
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!mst_pready_i) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_ABORT;
          end else begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mst_psel_o    = slv_psel_i;
    mst_penable_o = slv_penable_i;
    mst_pwrite_o  = slv_pwrite_i;
    mst_paddr_o   = slv_paddr_i;
    mst_pwdata_o  = slv_pwdata_i;
    slv_prdata_o  = mst_prdata_i;
    slv_pready_o  = mst_pready_i;
    slv_pslverr_o = mst_pslverr_i;
    err_o         = 1'b0;

    // Abort cycle: withdraw the stalled peripheral and answer the core ourselves.
    if (w_state == ST_ABORT) begin
      mst_psel_o    = 1'b0;
      mst_penable_o = 1'b0;
      slv_prdata_o  = ERR_DATA;
      slv_pready_o  = 1'b1;
      slv_pslverr_o = 1'b1;
      err_o         = 1'b1;
    end
  end

`ifdef APB_TIMEOUT_ERR_LOG_EN
  logic [APB_ADDR_WIDTH-1:0] r_err_addr;
  logic [7:0]                r_err_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (r_state == ST_ABORT) begin
      r_err_addr <= slv_paddr_i;
      r_err_cnt  <= sat_inc8(r_err_cnt);
    end
  end

  assign err_addr_o = r_err_addr;
  assign err_cnt_o  = r_err_cnt;
`else
  assign err_addr_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_apb_timeout_guard.sv
// Directed scoreboard bench for apb_timeout_guard with TIMEOUT_CYCLES=16.
module tb_apb_timeout_guard;

  localparam int TO = 16;
`ifdef APB_TIMEOUT_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slv_psel_i, slv_penable_i, slv_pwrite_i;
  logic [31:0] slv_paddr_i, slv_pwdata_i;
  logic [31:0] slv_prdata_o;
  logic        slv_pready_o, slv_pslverr_o;
  logic        mst_psel_o, mst_penable_o, mst_pwrite_o;
  logic [31:0] mst_paddr_o, mst_pwdata_o;
  logic [31:0] mst_prdata_i;
  logic        mst_pready_i, mst_pslverr_i;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [7:0]  err_cnt_o;

  typedef struct {
    logic        slverr;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_addr = '0;

  apb_timeout_guard #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_psel_i(slv_psel_i), .slv_penable_i(slv_penable_i), .slv_pwrite_i(slv_pwrite_i),
    .slv_paddr_i(slv_paddr_i), .slv_pwdata_i(slv_pwdata_i),
    .slv_prdata_o(slv_prdata_o), .slv_pready_o(slv_pready_o), .slv_pslverr_o(slv_pslverr_o),
    .mst_psel_o(mst_psel_o), .mst_penable_o(mst_penable_o), .mst_pwrite_o(mst_pwrite_o),
    .mst_paddr_o(mst_paddr_o), .mst_pwdata_o(mst_pwdata_o),
    .mst_prdata_i(mst_prdata_i), .mst_pready_i(mst_pready_i), .mst_pslverr_i(mst_pslverr_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_cnt"}, {24'd0, err_cnt_o}, LOG_EN ? 32'(exp_cnt) : 32'd0);
    chk({tag, "_addr"}, err_addr_o, LOG_EN ? exp_addr : 32'd0);
  endtask

  // One APB transfer; rdy is the access cycle with PREADY high (-1 = never).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int rdy, input bit quiet);
    exp_t e;
    bit   done;
    bit   stray_err;
    e.slverr = (rdy < 0) || (rdy >= TO);
    e.rdata  = e.slverr ? 32'hDEADBEEF : rdata;
    e.cyc    = e.slverr ? TO : rdy;
    sb.push_back(e);
    if (e.slverr) begin
      exp_cnt  = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      exp_addr = addr;
    end
    @(posedge clk); #1;
    slv_psel_i = 1'b1; slv_penable_i = 1'b0; slv_pwrite_i = wr;
    slv_paddr_i = addr; slv_pwdata_i = wdata;
    mst_pready_i = 1'b0; mst_prdata_i = rdata;
    @(negedge clk);
    if (!quiet) chk("setup_paddr", mst_paddr_o, addr);
    done = 1'b0;
    stray_err = 1'b0;
    for (int k = 0; k <= TO + 2 && !done; k++) begin
      @(posedge clk); #1;
      slv_penable_i = 1'b1;
      mst_pready_i  = (k == rdy);
      @(negedge clk);
      if (slv_pready_o) begin
        e = sb.pop_front();
        done = 1'b1;
        if (!quiet || e.cyc != k) chk("done_cycle", k, e.cyc);
        if (!quiet) begin
          chk("pslverr", {31'd0, slv_pslverr_o}, {31'd0, e.slverr});
          chk("prdata", slv_prdata_o, e.rdata);
          chk("err_pulse", {31'd0, err_o}, {31'd0, e.slverr});
          chk("mst_psel", {31'd0, mst_psel_o}, {31'd0, !e.slverr});
        end
      end else if (err_o) begin
        stray_err = 1'b1;
      end
    end
    if (!done) chk("response_timeout", 32'd0, 32'd1);
    if (!quiet) chk("no_early_err", {31'd0, stray_err}, 32'd0);
  endtask

  task automatic go_idle(input string tag);
    @(posedge clk); #1;
    slv_psel_i = 1'b0; slv_penable_i = 1'b0; mst_pready_i = 1'b0;
    @(negedge clk);
    chk({tag, "_err_low"}, {31'd0, err_o}, 32'd0);
    chk_log(tag);
  endtask

  initial begin
    bit any_err;
    rst_n = 1'b0;
    slv_psel_i = 1'b1; slv_penable_i = 1'b0; slv_pwrite_i = 1'b0;
    slv_paddr_i = 32'hCAFE_0004; slv_pwdata_i = 32'h5555_AAAA;
    mst_prdata_i = 32'h0BAD_F00D; mst_pready_i = 1'b0; mst_pslverr_i = 1'b0;
    #23;
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt_o}, 32'd0);
    chk("rst_addr", err_addr_o, 32'd0);
    chk("rst_pass_addr", mst_paddr_o, 32'hCAFE_0004);
    chk("rst_pass_rdata", slv_prdata_o, 32'h0BAD_F00D);
    slv_psel_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    xfer(32'h1A10_0000, 1'b1, 32'h0000_1234, 32'h0, 2, 1'b0);
    chk("wr_pwdata", mst_pwdata_o, 32'h0000_1234);
    go_idle("wr");

    xfer(32'h1A10_1000, 1'b0, 32'h0, 32'h1111_2222, -1, 1'b0);
    go_idle("rd_abort");

    xfer(32'h1A10_2000, 1'b0, 32'h0, 32'h3333_4444, TO - 1, 1'b0);
    go_idle("edge15");

    xfer(32'h1A10_3000, 1'b0, 32'h0, 32'h5555_6666, TO, 1'b0);
    go_idle("late_ready");

    xfer(32'h1A10_4000, 1'b1, 32'h77, 32'h7777_8888, 3, 1'b0);
    xfer(32'h1A10_5000, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    xfer(32'h1A10_6000, 1'b0, 32'h0, 32'h9999_AAAA, 0, 1'b0);
    go_idle("b2b");

    @(posedge clk); #1;
    slv_psel_i = 1'b1; slv_penable_i = 1'b0; slv_paddr_i = 32'h1A10_7000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      slv_penable_i = 1'b1; mst_pready_i = 1'b0;
    end
    @(posedge clk); #1;
    slv_psel_i = 1'b0; slv_penable_i = 1'b0;
    @(negedge clk);
    chk("drop_mst_psel", {31'd0, mst_psel_o}, 32'd0);
    any_err = err_o;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      any_err |= err_o;
    end
    chk("drop_no_err", {31'd0, any_err}, 32'd0);
    chk_log("drop");
    xfer(32'h1A10_8000, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    go_idle("fresh_window");

    for (int i = 0; i < 300; i++)
      xfer(32'h2000_0000 + 32'(i * 4), 1'b0, 32'h0, 32'h0, -1, 1'b1);
    go_idle("sat300");
    chk("sat300_model", 32'(exp_cnt), 32'd255);

    xfer(32'h3000_0010, 1'b1, 32'h1, 32'h0, -1, 1'b0);
    go_idle("sat_hold");

    @(posedge clk); #1;
    slv_psel_i = 1'b1; slv_penable_i = 1'b0; slv_paddr_i = 32'h1A10_9000;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      slv_penable_i = 1'b1; mst_pready_i = 1'b0;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0; exp_addr = '0;
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    chk("midrst_pslverr", {31'd0, slv_pslverr_o}, 32'd0);
    chk_log("midrst");
    @(negedge clk);
    slv_psel_i = 1'b0; slv_penable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(32'h1A10_A000, 1'b0, 32'h0, 32'hABCD_EF01, 1, 1'b0);
    go_idle("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
